// File: rtl/rule_pkg.sv
// rule_pkg
// Shared constants for the rule bus width converters. The 32-to-512
// packer and the 512-to-32 unpacker both take their widths from here.
// Provides the wide/narrow data widths, the words-per-beat count, the empty
// field widths, and a helper that turns an eop beat's empty byte count into
// the index of the last 32-bit word to emit.
package rule_pkg;

  localparam int RULE_WIDE_W         = 512;
  localparam int RULE_NARROW_W       = 32;
  localparam int RULE_WORDS          = 16;
  localparam int RULE_WIDE_EMPTY_W   = 6;
  localparam int RULE_NARROW_EMPTY_W = 2;

  localparam logic [RULE_WIDE_EMPTY_W-1:0] RULE_WIDE_LAST_BYTE = 6'd63;
  localparam logic [3:0]                   RULE_LAST_WORD      = 4'd15;

  // Index of the last valid byte is 63 - empty; dividing by four gives the
  // word holding it. Non-eop beats are always full.
  function automatic logic [3:0] rule_last_idx(input logic                         eop,
                                               input logic [RULE_WIDE_EMPTY_W-1:0] empty);
    logic [RULE_WIDE_EMPTY_W-1:0] last_byte;
    last_byte = RULE_WIDE_LAST_BYTE - empty;
    return eop ? last_byte[5:2] : RULE_LAST_WORD;
  endfunction

endpackage

// File: rtl/rule_unpacker_512_32_if.sv
// rule_unpacker_512_32_if
// Bundles the 512-bit input beat channel and the 32-bit output word channel
// of the rule unpacker.
//   in_rule_*  : wide beat stream (sop, eop, empty[5:0], valid, data[511:0], ready)
//   out_rule_* : narrow word stream (sop, eop, empty[1:0], valid, data[31:0], ready)
// Modport slave is the unpacker's view; master is the view of the
// surrounding logic that feeds beats and consumes words.
interface rule_unpacker_512_32_if;
  import rule_pkg::*;

  logic                           in_rule_sop;
  logic                           in_rule_eop;
  logic [RULE_WIDE_EMPTY_W-1:0]   in_rule_empty;
  logic                           in_rule_valid;
  logic [RULE_WIDE_W-1:0]         in_rule_data;
  logic                           in_rule_ready;

  logic                           out_rule_sop;
  logic                           out_rule_eop;
  logic [RULE_NARROW_EMPTY_W-1:0] out_rule_empty;
  logic                           out_rule_valid;
  logic [RULE_NARROW_W-1:0]       out_rule_data;
  logic                           out_rule_ready;

  modport slave (
    input  in_rule_sop, in_rule_eop, in_rule_empty, in_rule_valid, in_rule_data,
    output in_rule_ready,
    output out_rule_sop, out_rule_eop, out_rule_empty, out_rule_valid, out_rule_data,
    input  out_rule_ready
  );

  modport master (
    output in_rule_sop, in_rule_eop, in_rule_empty, in_rule_valid, in_rule_data,
    input  in_rule_ready,
    input  out_rule_sop, out_rule_eop, out_rule_empty, out_rule_valid, out_rule_data,
    output out_rule_ready
  );

endinterface

// File: rtl/rule_unpacker_512_32.sv
// rule_unpacker_512_32
// Serializes 512-bit rule beats into 32-bit rule words, least-significant
// word first, carrying sop/eop/empty framing through. An eop beat emits
// only the words that hold valid bytes; the last word reports empty mod 4.
// Ports:
//   clk       sole clock
//   rst       asynchronous active-high reset
//   rule_if   slave side of the wide-in / narrow-out rule stream interface
//   proto_err sticky framing error flag
// Optional feature: define RULE_UNPACK_CHK_EN to enable sop/eop framing
// checking on accepted beats; otherwise proto_err is tied to 0.
module rule_unpacker_512_32
  import rule_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rule_unpacker_512_32_if.slave rule_if,
  output logic                  proto_err
);

  logic                           buf_valid;
  logic [RULE_WIDE_W-1:0]         buf_data;
  logic                           buf_sop;
  logic                           buf_eop;
  logic [RULE_NARROW_EMPTY_W-1:0] buf_empty2;
  logic [3:0]                     last_idx;
  logic [3:0]                     idx;

  logic word_last;
  logic beat_acc;
  logic word_acc;

  assign word_last = (idx == last_idx);
  assign word_acc  = buf_valid & rule_if.out_rule_ready;

  // A new beat can load when the buffer is empty or when its final word is
  // leaving this cycle, which keeps one word per cycle across beats.
  assign rule_if.in_rule_ready = !rst & (!buf_valid | (rule_if.out_rule_ready & word_last));
  assign beat_acc              = rule_if.in_rule_valid & rule_if.in_rule_ready;

  // Holding register and word pointer. A beat load takes priority over
  // retiring the last word because both happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      buf_sop    <= 1'b0;
      buf_eop    <= 1'b0;
      buf_empty2 <= '0;
      last_idx   <= '0;
      idx        <= '0;
    end else if (beat_acc) begin
      buf_valid  <= 1'b1;
      buf_data   <= rule_if.in_rule_data;
      buf_sop    <= rule_if.in_rule_sop;
      buf_eop    <= rule_if.in_rule_eop;
      buf_empty2 <= rule_if.in_rule_eop ? rule_if.in_rule_empty[1:0] : 2'd0;
      last_idx   <= rule_last_idx(rule_if.in_rule_eop, rule_if.in_rule_empty);
      idx        <= '0;
    end else if (word_acc) begin
      if (!word_last) begin
        idx <= idx + 4'd1;
      end else begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Output fields come straight from the holding register; the word select
  // is a 16:1 mux on idx.
  assign rule_if.out_rule_valid = buf_valid;
  assign rule_if.out_rule_data  = buf_data[{idx, 5'd0} +: RULE_NARROW_W];
  assign rule_if.out_rule_sop   = buf_valid & buf_sop & (idx == 4'd0);
  assign rule_if.out_rule_eop   = buf_valid & buf_eop & word_last;
  assign rule_if.out_rule_empty = rule_if.out_rule_eop ? buf_empty2 : 2'd0;

`ifdef RULE_UNPACK_CHK_EN
  logic in_pkt;

  // Framing check on accepted beats: a sop inside a packet or a non-sop
  // outside one latches the error until reset. Data flow is untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt    <= 1'b0;
      proto_err <= 1'b0;
    end else if (beat_acc) begin
      if ((rule_if.in_rule_sop & in_pkt) | (!rule_if.in_rule_sop & !in_pkt)) begin
        proto_err <= 1'b1;
      end
      if (rule_if.in_rule_eop) begin
        in_pkt <= 1'b0;
      end else if (rule_if.in_rule_sop) begin
        in_pkt <= 1'b1;
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rule_unpacker_512_32.sv
// tb_rule_unpacker_512_32
// Bench for rule_unpacker_512_32. A byte-level model turns every accepted
// beat into the list of words it must produce; a negedge monitor compares
// the DUT against that list each cycle, and directed tests pin a few
// outputs to literal values.
module tb_rule_unpacker_512_32;
  import rule_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;

  always #5 clk = ~clk;

  rule_unpacker_512_32_if bus ();

  rule_unpacker_512_32 dut (
    .clk       (clk),
    .rst       (rst),
    .rule_if   (bus),
    .proto_err (proto_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        last_in_beat;
  } exp_word_t;

  exp_word_t   exp_q[$];
  logic [35:0] out_log[$];
  int          out_cycle[$];
  int          cycle_cnt    = 0;
  int          vec_cnt      = 0;
  int          err_cnt      = 0;
  logic        exp_err      = 1'b0;
  logic        model_in_pkt = 1'b0;
  bit          rand_ready   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Expand one accepted beat into its output words, counting in bytes.
  task automatic model_push(input logic sop, input logic eop, input logic [5:0] empty,
                            input logic [511:0] data);
    int valid_bytes;
    int nwords;
    exp_word_t w;
    valid_bytes = eop ? 64 - int'(empty) : 64;
    nwords      = (valid_bytes + 3) / 4;
    for (int k = 0; k < nwords; k++) begin
      w.data         = data[32*k +: 32];
      w.sop          = sop && (k == 0);
      w.eop          = eop && (k == nwords - 1);
      w.empty        = w.eop ? 2'(4*nwords - valid_bytes) : 2'd0;
      w.last_in_beat = (k == nwords - 1);
      exp_q.push_back(w);
    end
`ifdef RULE_UNPACK_CHK_EN
    if ((sop && model_in_pkt) || (!sop && !model_in_pkt)) exp_err = 1'b1;
    if (eop) model_in_pkt = 1'b0;
    else if (sop) model_in_pkt = 1'b1;
`endif
  endtask

  // Monitor: compares outputs mid-cycle, retires handshaken words, and
  // queues words for beats that will be accepted at the coming edge.
  always @(negedge clk) begin : monitor
    logic exp_ready;
    exp_word_t e;
    cycle_cnt++;
    if (rst) begin
      exp_q.delete();
      model_in_pkt = 1'b0;
      exp_err      = 1'b0;
      checkOutput("reset_quiet",
                  {bus.in_rule_ready, bus.out_rule_valid, bus.out_rule_sop, bus.out_rule_eop,
                   bus.out_rule_empty, bus.out_rule_data, proto_err}, 64'd0);
    end else begin
      exp_ready = (exp_q.size() == 0) || (bus.out_rule_ready && exp_q[0].last_in_beat);
      checkOutput("in_ready", 64'(bus.in_rule_ready), 64'(exp_ready));
      checkOutput("proto_err", 64'(proto_err), 64'(exp_err));
      checkOutput("out_valid", 64'(bus.out_rule_valid), 64'(exp_q.size() != 0));
      if (bus.out_rule_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        checkOutput("word",
                    {bus.out_rule_data, bus.out_rule_sop, bus.out_rule_eop, bus.out_rule_empty},
                    {e.data, e.sop, e.eop, e.empty});
      end else if (!bus.out_rule_valid) begin
        checkOutput("idle_flags", {bus.out_rule_sop, bus.out_rule_eop, bus.out_rule_empty}, 64'd0);
      end
      if (bus.out_rule_valid && bus.out_rule_ready) begin
        out_log.push_back({bus.out_rule_data, bus.out_rule_sop, bus.out_rule_eop, bus.out_rule_empty});
        out_cycle.push_back(cycle_cnt);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (bus.in_rule_valid && bus.in_rule_ready) begin
        model_push(bus.in_rule_sop, bus.in_rule_eop, bus.in_rule_empty, bus.in_rule_data);
      end
    end
  end

  // Consumer: always ready, or a coin flip per cycle during the stall test.
  always @(posedge clk) begin
    #1;
    bus.out_rule_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [511:0] make_beat(input logic [31:0] base);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = base + 32'(k);
    return d;
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
    return d;
  endfunction

  // Present one beat from just after an edge and hold it until accepted.
  task automatic applyStimulus(input logic sop, input logic eop, input logic [5:0] empty,
                               input logic [511:0] data);
    bit done;
    done = 1'b0;
    bus.in_rule_sop   = sop;
    bus.in_rule_eop   = eop;
    bus.in_rule_empty = empty;
    bus.in_rule_data  = data;
    bus.in_rule_valid = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = bus.in_rule_ready;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic go_idle();
    bus.in_rule_valid = 1'b0;
    bus.in_rule_sop   = 1'b0;
    bus.in_rule_eop   = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(posedge clk);
      #2;
      done = (exp_q.size() == 0) && !bus.out_rule_valid;
    end
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_rule_sop    = 1'b0;
    bus.in_rule_eop    = 1'b0;
    bus.in_rule_empty  = '0;
    bus.in_rule_data   = '0;
    bus.in_rule_valid  = 1'b1;
    bus.out_rule_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    go_idle();
    rst = 1'b0;

    $display("[TB] full single-beat packet");
    out_log.delete();
    applyStimulus(1'b1, 1'b1, 6'd0, make_beat(32'h1000_0000));
    go_idle();
    wait_drain();
    checkOutput("t1_count", 64'(out_log.size()), 64'd16);
    checkOutput("t1_word0", 64'(out_log[0]), {32'h1000_0000, 1'b1, 1'b0, 2'd0});
    checkOutput("t1_word15", 64'(out_log[15]), {32'h1000_000F, 1'b0, 1'b1, 2'd0});

    $display("[TB] partial eop beats");
    out_log.delete();
    applyStimulus(1'b1, 1'b1, 6'd6, make_beat(32'h2000_0000));
    go_idle();
    wait_drain();
    checkOutput("t2_count", 64'(out_log.size()), 64'd15);
    checkOutput("t2_last", 64'(out_log[14]), {32'h2000_000E, 1'b0, 1'b1, 2'd2});
    out_log.delete();
    applyStimulus(1'b1, 1'b1, 6'd63, make_beat(32'h3000_0000));
    go_idle();
    wait_drain();
    checkOutput("t2b_count", 64'(out_log.size()), 64'd1);
    checkOutput("t2b_word", 64'(out_log[0]), {32'h3000_0000, 1'b1, 1'b1, 2'd3});

    $display("[TB] three-beat packet back to back");
    out_log.delete();
    out_cycle.delete();
    applyStimulus(1'b1, 1'b0, 6'd0, make_beat(32'h4000_0000));
    applyStimulus(1'b0, 1'b0, 6'd17, make_beat(32'h4100_0000));
    applyStimulus(1'b0, 1'b1, 6'd0, make_beat(32'h4200_0000));
    go_idle();
    wait_drain();
    checkOutput("t3_count", 64'(out_log.size()), 64'd48);
    checkOutput("t3_no_bubble", 64'(out_cycle[47] - out_cycle[0]), 64'd47);
    checkOutput("t3_word16", 64'(out_log[16]), {32'h4100_0000, 1'b0, 1'b0, 2'd0});
    checkOutput("t3_word47", 64'(out_log[47]), {32'h4200_000F, 1'b0, 1'b1, 2'd0});

    $display("[TB] random stalls over 20 packets");
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        applyStimulus(b == 0, b == nb - 1, 6'($urandom_range(0, 63)), rand_beat());
      end
      if ($urandom_range(0, 1) == 1) begin
        go_idle();
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    go_idle();
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a packet");
    out_log.delete();
    applyStimulus(1'b1, 1'b1, 6'd0, make_beat(32'h5000_0000));
    go_idle();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5_pre_reset_word", 64'(bus.out_rule_data), 64'h5000_0005);
    rst = 1'b1;
    #1;
    checkOutput("t5_reset_now",
                {bus.in_rule_ready, bus.out_rule_valid, bus.out_rule_sop, bus.out_rule_eop,
                 bus.out_rule_empty, bus.out_rule_data, proto_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_log.delete();
    applyStimulus(1'b1, 1'b1, 6'd60, make_beat(32'h6000_0000));
    go_idle();
    wait_drain();
    checkOutput("t5_count", 64'(out_log.size()), 64'd1);
    checkOutput("t5_word", 64'(out_log[0]), {32'h6000_0000, 1'b1, 1'b1, 2'd0});

    $display("[TB] two sop beats without eop");
    applyStimulus(1'b1, 1'b0, 6'd0, make_beat(32'h7000_0000));
    applyStimulus(1'b1, 1'b0, 6'd0, make_beat(32'h7100_0000));
    go_idle();
`ifdef RULE_UNPACK_CHK_EN
    checkOutput("t6_err_set", 64'(proto_err), 64'd1);
`else
    checkOutput("t6_err_tied", 64'(proto_err), 64'd0);
`endif
    applyStimulus(1'b0, 1'b1, 6'd0, make_beat(32'h7200_0000));
    go_idle();
    wait_drain();
`ifdef RULE_UNPACK_CHK_EN
    checkOutput("t6_err_sticky", 64'(proto_err), 64'd1);
`else
    checkOutput("t6_err_still_0", 64'(proto_err), 64'd0);
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_err_cleared", 64'(proto_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rule_unpacker_512_32.md
# rule_unpacker_512_32

Serializes 512-bit rule flits (the PCIe-side rule bus format) into a 32-bit rule word stream for the rule-update path feeding the matcher tables. Each 512-bit beat is split into sixteen 32-bit words, least-significant word first, and packet framing (sop/eop/empty) is carried through. Sits between the PCIe rule DMA output and the 32-bit rule consumers, so it is the reverse of the 32-to-512 rule packing path.

## Interface
- No parameters. Widths are fixed at 512 bits in and 32 bits out, taken from package constants.
- clk  input  1  sole clock
- rst  input  1  reset, asynchronous, active-high
- in_rule_sop  input  1  first beat of packet
- in_rule_eop  input  1  last beat of packet
- in_rule_empty  input  6  empty bytes in eop beat; ignored (treated as 0) on non-eop beats
- in_rule_valid  input  1  beat valid
- in_rule_data  input  512  beat data; word k = bits [32k+31:32k]
- in_rule_ready  output  1  beat accepted when valid & ready
- out_rule_sop  output  1  first word of packet
- out_rule_eop  output  1  last word of packet
- out_rule_empty  output  2  empty bytes in eop word; 0 otherwise
- out_rule_valid  output  1  word valid
- out_rule_data  output  32  word data
- out_rule_ready  input  1  word consumed when valid & ready
- proto_err  output  1  sticky framing error; constant 0 unless RULE_UNPACK_CHK_EN

## Operation
- State:
  - buf_valid: holding register is occupied.
  - buf_data[511:0], buf_sop, buf_eop.
  - last_idx[3:0]: index of the last word to emit from the buffered beat.
  - idx[3:0]: index of the word currently presented.
- On beat accept:
  - Load buf_data, buf_sop and buf_eop.
  - Set idx=0 and buf_valid=1.
  - last_idx = (63 - in_rule_empty) >> 2 if eop, else 15.
  - buf_empty2 = in_rule_empty[1:0] if eop, else 0.
- Output fields, all driven from registers:
  - out_rule_valid = buf_valid.
  - out_rule_data = buf_data word[idx].
  - out_rule_sop = buf_valid & buf_sop & (idx==0).
  - out_rule_eop = buf_valid & buf_eop & (idx==last_idx).
  - out_rule_empty = out_rule_eop ? buf_empty2 : 0.
- On word accept:
  - If idx != last_idx: idx <= idx+1.
  - Else: buf_valid clears, unless a new beat is accepted in the same cycle, in which case that beat loads.
- in_rule_ready = !rst & (!buf_valid | (out_rule_ready & idx==last_idx)). This is a combinational path from out_rule_ready and is permitted.
- Words beyond last_idx in an eop beat are never emitted.
- A single-beat packet has sop and eop both set. A one-word packet gives out sop=eop=1 on the same word.
- Empty arithmetic:
  - Valid bytes in the beat = 64 - empty.
  - Words emitted = last_idx + 1.
  - Empty byte count in the last word = empty mod 4.
  - Example: empty=63 gives last_idx=0 and out_empty=3.

## Timing
- Reset values: in_rule_ready=0 while rst is high. out_rule_valid, out_rule_sop, out_rule_eop, out_rule_empty, out_rule_data, idx, buf_valid and proto_err are all 0.
- Latency: a beat accepted at edge N presents word 0 after edge N. The first word is visible in cycle N+1.
- Throughput: 1 word/cycle sustained across beat boundaries, with no bubble when the upstream is valid.
- Output stability: while out_rule_valid & !out_rule_ready, data, sop, eop and empty hold stable.
- Reset mid-packet discards the buffered beat and remaining words immediately (asynchronous). The next accepted beat is treated fresh.

## Configuration
- RULE_UNPACK_CHK_EN defined:
  - An in_pkt flag tracks framing. It sets on an accepted sop beat without eop and clears on an accepted eop beat.
  - proto_err sets, and stays set until rst, on either of:
    - an accepted sop beat while in_pkt;
    - an accepted non-sop beat while !in_pkt.
  - Data flow is unaffected; offending beats are still serialized.
- RULE_UNPACK_CHK_EN undefined: proto_err is tied to 0 and there is no in_pkt logic.

## Structure
- Shared package rule_pkg holds:
  - RULE_WIDE_W=512, RULE_NARROW_W=32;
  - RULE_WORDS=16, RULE_WIDE_EMPTY_W=6, RULE_NARROW_EMPTY_W=2.
- The packer and unpacker both use these constants.
- No sub-module. The 16:1 word mux and the control logic stay in one file.

## Test plan
- Single beat, sop=eop=1, empty=0, word k = 32'h1000_0000+k, out_ready=1 -> 16 words in order; sop on word 0; eop on word 15 with empty=0.
- Single beat, empty=6 -> 15 words (last_idx=14); eop word has empty=2. Also empty=63 -> 1 word with sop=eop=1 and empty=3.
- Three-beat packet with valid held high and out_ready=1 -> 48 contiguous words with no bubble; in_ready high only on idx==15 cycles after the first load; sop only on word 0; eop only on word 47.
- Random out_ready (about 50% duty) over 20 packets with random empty -> scoreboard matches byte-exact; outputs are stable during stalls.
- Assert rst mid-packet at word 5 -> all outputs are 0 immediately; after release, a new packet starts with sop on its word 0 and no stale words appear.
- RULE_UNPACK_CHK_EN: two consecutive sop beats without eop -> proto_err=1 from the cycle after the second accept, and it remains 1 until rst.
